// File: rtl/div_unit.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU), radix-2 restoring.
// Holds the pipeline while running and returns one result strobe.
module div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic [4:0]  rd_addr_in,
    input  logic        flush,
    output logic        hold_en,
    output logic        busy,
    output logic        result_valid,
    output logic [31:0] result,
    output logic [4:0]  rd_addr_out
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [31:0] dvd_q;
    logic [31:0] dvs_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] result_q;
    logic [4:0]  rd_q;
    logic        is_rem_q;
    logic        neg_q_q;
    logic        neg_r_q;

    logic        is_rem;
    logic        is_sgn;
    logic        div_zero;
    logic        ovf;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] spec_res;

    // Unlisted funct3 codes decode as DIVU (not signed, not remainder).
    assign is_rem   = funct3[2] & funct3[1];
    assign is_sgn   = funct3[2] & ~funct3[0];
    assign abs_a    = (is_sgn && dividend[31]) ? -dividend : dividend;
    assign abs_b    = (is_sgn && divisor[31]) ? -divisor : divisor;
    assign div_zero = (divisor == 32'h0);
    assign ovf      = is_sgn && (dividend == 32'h8000_0000)
                      && (divisor == 32'hFFFF_FFFF);
    assign spec_res = div_zero ? (is_rem ? dividend : 32'hFFFF_FFFF)
                               : (is_rem ? 32'h0 : 32'h8000_0000);

    logic [32:0] shifted;
    logic [32:0] trial;
    logic [31:0] rem_d;
    logic [31:0] quot_d;
    logic [31:0] fin;

    assign shifted = {rem_q, dvd_q[count_q]};
    assign trial   = shifted - {1'b0, dvs_q};
    assign rem_d   = trial[32] ? shifted[31:0] : trial[31:0];

    always_comb begin
        quot_d          = quot_q;
        quot_d[count_q] = ~trial[32];
    end

    assign fin = is_rem_q ? (neg_r_q ? -rem_d : rem_d)
                          : (neg_q_q ? -quot_d : quot_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= 5'd0;
            dvd_q    <= 32'h0;
            dvs_q    <= 32'h0;
            rem_q    <= 32'h0;
            quot_q   <= 32'h0;
            result_q <= 32'h0;
            rd_q     <= 5'd0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !flush) begin
                        rd_q     <= rd_addr_in;
                        is_rem_q <= is_rem;
                        neg_q_q  <= is_sgn & ~is_rem
                                    & (dividend[31] ^ divisor[31]);
                        neg_r_q  <= is_sgn & is_rem & dividend[31];
                        dvd_q    <= abs_a;
                        dvs_q    <= abs_b;
                        rem_q    <= 32'h0;
                        quot_q   <= 32'h0;
                        count_q  <= 5'd31;
                        if (div_zero || ovf) begin
                            result_q <= spec_res;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        state_q <= IDLE;
                    end else begin
                        rem_q  <= rem_d;
                        quot_q <= quot_d;
                        if (count_q == 5'd0) begin
                            result_q <= fin;
                            state_q  <= DONE;
                        end else begin
                            count_q <= count_q - 5'd1;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE) && !flush;
    assign hold_en      = ((state_q == IDLE) && start && !flush)
                          || (state_q == CALC);
    assign result       = result_q;
    assign rd_addr_out  = rd_q;
endmodule
